// File: rtl/zeroriscy_multdiv_arbiter.sv
// zeroriscy_multdiv_arbiter
//   Shares the single mult/div unit between the core EX stage ("core") and
//   the matrix-multiply accelerator's scalar-arithmetic path ("acc").
//   One request is granted at a time. Its operands are latched, the unit
//   enables are held until md_ready_i, and the registered result goes back
//   to the owner with a one-cycle rvalid pulse.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   core_* / acc_*              request side: req, div, operator, signed, op_a, op_b
//   core_kill_i                 discard the core's pending or in-flight operation
//   core_gnt_o / acc_gnt_o      one-cycle grant (operands captured on this edge)
//   core_rvalid_o/acc_rvalid_o  one-cycle result valid
//   core_rdata_o / acc_rdata_o  result register (shared by both ports)
//   md_*                        mult/div unit side: enables, operator, signed,
//                               operands, ready, result
//   busy_o                      high whenever the sequencer is not idle
//
// Handshake: a requester raises *_req_i with stable operands and holds it
// until it sees *_gnt_o high at a rising edge; that edge captures the
// operands. Grants are only issued in IDLE. The result is returned later as
// a single-cycle *_rvalid_o with *_rdata_o valid in that same cycle; there
// is no back-pressure on the result.
module zeroriscy_multdiv_arbiter #(
    parameter bit PRIO_MODE = 1'b0  // 0: core fixed priority, 1: round-robin
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req_i,
    input  logic        core_div_i,
    input  logic [1:0]  core_operator_i,
    input  logic [1:0]  core_signed_i,
    input  logic [31:0] core_op_a_i,
    input  logic [31:0] core_op_b_i,
    input  logic        core_kill_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,

    input  logic        acc_req_i,
    input  logic        acc_div_i,
    input  logic [1:0]  acc_operator_i,
    input  logic [1:0]  acc_signed_i,
    input  logic [31:0] acc_op_a_i,
    input  logic [31:0] acc_op_b_i,
    output logic        acc_gnt_o,
    output logic        acc_rvalid_o,
    output logic [31:0] acc_rdata_o,

    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    input  logic        md_ready_i,
    input  logic [31:0] md_result_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_acc_q;   // owner of the current/last operation
    logic        last_acc_q;    // last granted port, for round-robin
    logic        killed_q;
    logic        div_q;
    logic [1:0]  operator_q;
    logic [1:0]  signed_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] result_q;

    // A kill in IDLE masks the core request for that cycle only.
    logic core_eligible;
    assign core_eligible = core_req_i && !core_kill_i;

    always_comb begin
        state_d    = state_q;
        core_gnt_o = 1'b0;
        acc_gnt_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_eligible && acc_req_i) begin
                    // Conflict: fixed priority, or the port that did not
                    // win last time.
                    if (PRIO_MODE == 1'b0 || last_acc_q) begin
                        core_gnt_o = 1'b1;
                    end else begin
                        acc_gnt_o = 1'b1;
                    end
                end else if (core_eligible) begin
                    core_gnt_o = 1'b1;
                end else if (acc_req_i) begin
                    acc_gnt_o = 1'b1;
                end
                if (core_gnt_o || acc_gnt_o) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (md_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Guarantees one cycle with enables low before the next op.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_acc_q <= 1'b0;
            last_acc_q  <= 1'b1;
            killed_q    <= 1'b0;
            div_q       <= 1'b0;
            operator_q  <= 2'b00;
            signed_q    <= 2'b00;
            op_a_q      <= 32'h0;
            op_b_q      <= 32'h0;
            result_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (core_gnt_o || acc_gnt_o) begin
                owner_acc_q <= acc_gnt_o;
                last_acc_q  <= acc_gnt_o;
                killed_q    <= 1'b0;
                div_q       <= acc_gnt_o ? acc_div_i       : core_div_i;
                operator_q  <= acc_gnt_o ? acc_operator_i  : core_operator_i;
                signed_q    <= acc_gnt_o ? acc_signed_i    : core_signed_i;
                op_a_q      <= acc_gnt_o ? acc_op_a_i      : core_op_a_i;
                op_b_q      <= acc_gnt_o ? acc_op_b_i      : core_op_b_i;
            end
            if (state_q == BUSY) begin
                // The unit cannot be aborted; a kill only drops the result.
                if (!owner_acc_q && core_kill_i) begin
                    killed_q <= 1'b1;
                end
                if (md_ready_i) begin
                    result_q <= md_result_i;
                end
            end
        end
    end

    assign md_mult_en_o     = (state_q == BUSY) && !div_q;
    assign md_div_en_o      = (state_q == BUSY) && div_q;
    assign md_operator_o    = operator_q;
    assign md_signed_mode_o = signed_q;
    assign md_op_a_o        = op_a_q;
    assign md_op_b_o        = op_b_q;

    // A kill arriving in the DONE cycle itself also suppresses the result.
    assign core_rvalid_o = (state_q == DONE) && !owner_acc_q && !killed_q && !core_kill_i;
    assign acc_rvalid_o  = (state_q == DONE) && owner_acc_q;
    assign core_rdata_o  = result_q;
    assign acc_rdata_o   = result_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_zeroriscy_multdiv_arbiter.sv
module tb_zeroriscy_multdiv_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // index 0: PRIO_MODE=0 instance, index 1: PRIO_MODE=1 instance
  logic        creq[2], cdiv[2], ckill[2], areq[2], adiv[2];
  logic [1:0]  cop[2], csg[2], aop[2], asg[2];
  logic [31:0] ca[2], cb[2], aa[2], ab[2];
  logic        cgnt[2], agnt[2], crv[2], arv[2], mul_en[2], div_en[2], busy[2];
  logic        md_ready[2];
  logic [31:0] crd[2], ard[2], ma[2], mb[2], md_result[2];
  logic [1:0]  mop[2], msg[2];

  int          lat[2];
  int          cnt[2];
  logic        noise_rdy[2];
  logic [31:0] noise_res[2];

  int n_chk = 0;
  int n_pass = 0;

  zeroriscy_multdiv_arbiter #(.PRIO_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .core_req_i(creq[0]), .core_div_i(cdiv[0]), .core_operator_i(cop[0]),
    .core_signed_i(csg[0]), .core_op_a_i(ca[0]), .core_op_b_i(cb[0]),
    .core_kill_i(ckill[0]), .core_gnt_o(cgnt[0]), .core_rvalid_o(crv[0]),
    .core_rdata_o(crd[0]),
    .acc_req_i(areq[0]), .acc_div_i(adiv[0]), .acc_operator_i(aop[0]),
    .acc_signed_i(asg[0]), .acc_op_a_i(aa[0]), .acc_op_b_i(ab[0]),
    .acc_gnt_o(agnt[0]), .acc_rvalid_o(arv[0]), .acc_rdata_o(ard[0]),
    .md_mult_en_o(mul_en[0]), .md_div_en_o(div_en[0]), .md_operator_o(mop[0]),
    .md_signed_mode_o(msg[0]), .md_op_a_o(ma[0]), .md_op_b_o(mb[0]),
    .md_ready_i(md_ready[0]), .md_result_i(md_result[0]), .busy_o(busy[0])
  );

  zeroriscy_multdiv_arbiter #(.PRIO_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .core_req_i(creq[1]), .core_div_i(cdiv[1]), .core_operator_i(cop[1]),
    .core_signed_i(csg[1]), .core_op_a_i(ca[1]), .core_op_b_i(cb[1]),
    .core_kill_i(ckill[1]), .core_gnt_o(cgnt[1]), .core_rvalid_o(crv[1]),
    .core_rdata_o(crd[1]),
    .acc_req_i(areq[1]), .acc_div_i(adiv[1]), .acc_operator_i(aop[1]),
    .acc_signed_i(asg[1]), .acc_op_a_i(aa[1]), .acc_op_b_i(ab[1]),
    .acc_gnt_o(agnt[1]), .acc_rvalid_o(arv[1]), .acc_rdata_o(ard[1]),
    .md_mult_en_o(mul_en[1]), .md_div_en_o(div_en[1]), .md_operator_o(mop[1]),
    .md_signed_mode_o(msg[1]), .md_op_a_o(ma[1]), .md_op_b_o(mb[1]),
    .md_ready_i(md_ready[1]), .md_result_i(md_result[1]), .busy_o(busy[1])
  );

  // ---------------- mult/div unit stand-in ----------------
  // op[0] selects remainder for divides; signed mode non-zero means signed.
  function automatic logic [31:0] calc(logic d, logic [1:0] op, logic [1:0] sg,
                                       logic [31:0] a, logic [31:0] b);
    if (!d) return a * b;
    if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
    if (sg != 2'b00) return op[0] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return op[0] ? a % b : a / b;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      cnt[i] <= (rst || !(mul_en[i] || div_en[i])) ? 0 : cnt[i] + 1;
  end

  // Ready/result are random noise whenever the unit is not enabled.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      md_ready[i]  = noise_rdy[i];
      md_result[i] = noise_res[i];
      if (mul_en[i] || div_en[i]) begin
        md_ready[i]  = (cnt[i] == lat[i]);
        md_result[i] = calc(div_en[i], mop[i], msg[i], ma[i], mb[i]);
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      creq[i] = 0; cdiv[i] = 0; cop[i] = 0; csg[i] = 0; ca[i] = 0; cb[i] = 0;
      ckill[i] = 0; areq[i] = 0; adiv[i] = 0; aop[i] = 0; asg[i] = 0;
      aa[i] = 0; ab[i] = 0; lat[i] = 0; noise_rdy[i] = 0; noise_res[i] = 0;
    end
  endtask

  task automatic set_req(int i, bit acc, logic d, logic [1:0] op, logic [1:0] sg,
                         logic [31:0] a, logic [31:0] b);
    if (acc) begin
      areq[i] = 1; adiv[i] = d; aop[i] = op; asg[i] = sg; aa[i] = a; ab[i] = b;
    end else begin
      creq[i] = 1; cdiv[i] = d; cop[i] = op; csg[i] = sg; ca[i] = a; cb[i] = b;
    end
  endtask

  task automatic check_reset(int i, string nm);
    check({nm, " core_gnt"}, cgnt[i], 0);
    check({nm, " acc_gnt"}, agnt[i], 0);
    check({nm, " core_rvalid"}, crv[i], 0);
    check({nm, " acc_rvalid"}, arv[i], 0);
    check({nm, " core_rdata"}, crd[i], 0);
    check({nm, " acc_rdata"}, ard[i], 0);
    check({nm, " mult_en"}, mul_en[i], 0);
    check({nm, " div_en"}, div_en[i], 0);
    check({nm, " operator"}, mop[i], 0);
    check({nm, " signed"}, msg[i], 0);
    check({nm, " op_a"}, ma[i], 0);
    check({nm, " op_b"}, mb[i], 0);
    check({nm, " busy"}, busy[i], 0);
  endtask

  task automatic wait_idle(string nm);
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1]) ok = 1;
      else step();
    end
    check({nm, " idle"}, ok, 1);
  endtask

  // ---------------- table-driven single operations ----------------
  typedef struct {
    logic        acc;
    logic        d;
    logic [1:0]  op;
    logic [1:0]  sg;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  // Called at a drive point with instance i idle; returns at the DONE negedge.
  task automatic do_op(int i, vec_t v, string nm);
    bit got = 0;
    int nmul = 0, ndiv = 0, nboth = 0, t = 0;
    lat[i] = v.lat;
    set_req(i, v.acc, v.d, v.op, v.sg, v.a, v.b);
    @(negedge clk);
    check({nm, " gnt"}, v.acc ? agnt[i] : cgnt[i], 1);
    check({nm, " other gnt"}, v.acc ? cgnt[i] : agnt[i], 0);
    step();
    if (v.acc) areq[i] = 0; else creq[i] = 0;
    while (!got && t < v.lat + 6) begin
      @(negedge clk);
      if (t == 0) begin
        check({nm, " md_op_a"}, ma[i], v.a);
        check({nm, " md_op_b"}, mb[i], v.b);
        check({nm, " md_operator"}, mop[i], v.op);
        check({nm, " busy"}, busy[i], 1);
      end
      if (mul_en[i]) nmul++;
      if (div_en[i]) ndiv++;
      if (mul_en[i] && div_en[i]) nboth++;
      if (crv[i] || arv[i]) begin
        got = 1;
        check({nm, " rvalid owner"}, v.acc ? arv[i] : crv[i], 1);
        check({nm, " rvalid other"}, v.acc ? crv[i] : arv[i], 0);
        check({nm, " rdata"}, v.acc ? ard[i] : crd[i], v.exp);
        check({nm, " en low in done"}, {mul_en[i], div_en[i]}, 0);
        check({nm, " latency"}, t, v.lat + 1);
      end else begin
        step();
        t++;
      end
    end
    check({nm, " completed"}, got, 1);
    check({nm, " mult_en cycles"}, nmul, v.d ? 0 : v.lat + 1);
    check({nm, " div_en cycles"}, ndiv, v.d ? v.lat + 1 : 0);
    check({nm, " both en"}, nboth, 0);
  endtask

  // ---------------- randomized run against a transaction model ----------------
  task automatic gen(output logic d, output logic [1:0] op, output logic [1:0] sg,
                     output logic [31:0] a, output logic [31:0] b);
    d  = 1'($urandom_range(0, 1));
    op = d ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
    sg = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    a  = $urandom;
    b  = d ? 32'($urandom_range(1, 1000)) : $urandom;
  endtask

  task automatic rand_run(int i, int ncyc);
    bit pc = 0, pa = 0, infl = 0, own_acc = 0, kld = 0, last_acc = 1, odiv = 0;
    bit drained = 0;
    bit egc, ega, erc, era, eb, een;
    int gcyc = 0, dcyc = 0, olat;
    logic [31:0] eres = 0;
    logic d; logic [1:0] op, sg; logic [31:0] a, b;
    string nm;
    for (int cyc = 0; cyc < ncyc + 300 && !drained; cyc++) begin
      step();
      if (!pc) creq[i] = 0;
      if (!pa) areq[i] = 0;
      if (cyc < ncyc) begin
        if (!pc && $urandom_range(0, 2) == 0) begin
          gen(d, op, sg, a, b); set_req(i, 0, d, op, sg, a, b); pc = 1;
        end
        if (!pa && $urandom_range(0, 2) == 0) begin
          gen(d, op, sg, a, b); set_req(i, 1, d, op, sg, a, b); pa = 1;
        end
        ckill[i]     = ($urandom_range(0, 9) == 0);
        noise_rdy[i] = 1'($urandom_range(0, 1));
        noise_res[i] = $urandom;
      end else begin
        ckill[i] = 0;
      end
      @(negedge clk);
      nm = $sformatf("rand%0d c%0d", i, cyc);
      // an operation granted at G with latency L is in the unit G+1..G+1+L,
      // returns at G+2+L and the port is free again from G+3+L
      if (infl && cyc > dcyc) infl = 0;
      if (infl && !own_acc && cyc > gcyc && ckill[i]) kld = 1;
      eb  = infl && cyc > gcyc;
      een = eb && cyc < dcyc;
      erc = infl && cyc == dcyc && !own_acc && !kld;
      era = infl && cyc == dcyc && own_acc;
      egc = !infl && pc && !ckill[i] && (!pa || i == 0 || last_acc);
      ega = !infl && pa && !egc;
      check({nm, " core_gnt"}, cgnt[i], egc);
      check({nm, " acc_gnt"}, agnt[i], ega);
      check({nm, " core_rvalid"}, crv[i], erc);
      check({nm, " acc_rvalid"}, arv[i], era);
      check({nm, " busy"}, busy[i], eb);
      check({nm, " mult_en"}, mul_en[i], een && !odiv);
      check({nm, " div_en"}, div_en[i], een && odiv);
      if (erc) check({nm, " core_rdata"}, crd[i], eres);
      if (era) check({nm, " acc_rdata"}, ard[i], eres);
      if (egc || ega) begin
        infl = 1; own_acc = ega; gcyc = cyc; kld = 0; last_acc = ega;
        olat = $urandom_range(0, 6);
        lat[i] = olat;
        dcyc = cyc + olat + 2;
        odiv = ega ? adiv[i] : cdiv[i];
        eres = ega ? calc(adiv[i], aop[i], asg[i], aa[i], ab[i])
                   : calc(cdiv[i], cop[i], csg[i], ca[i], cb[i]);
        if (ega) pa = 0; else pc = 0;
      end
      if (cyc >= ncyc && !pc && !pa && !infl) drained = 1;
    end
    check($sformatf("rand%0d drained", i), drained, 1);
    creq[i] = 0; areq[i] = 0; ckill[i] = 0; noise_rdy[i] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int win0[$];
    int win1[$];
    bit saw_crv, saw_rdy;
    int nen;

    //            acc   d     op    sg    a              b              lat exp
    vecs[0] = '{1'b0, 1'b0, 2'd0, 2'd0, 32'd7,         32'hFFFF_FFFD, 2,  32'hFFFF_FFEB};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 2'd3, 32'd100,       32'd7,         33, 32'd14};
    vecs[2] = '{1'b1, 1'b1, 2'd3, 2'd3, 32'd100,       32'd7,         5,  32'd2};
    vecs[3] = '{1'b0, 1'b1, 2'd2, 2'd0, 32'hFFFF_FFF0, 32'd16,        0,  32'h0FFF_FFFF};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 2'd3, 32'hFFFF_FFF9, 32'd2,         1,  32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 2'd0, 32'h0001_0000, 32'h0001_0000, 3,  32'h0};
    vecs[6] = '{1'b0, 1'b1, 2'd2, 2'd3, 32'd5,         32'd0,         4,  32'hFFFF_FFFF};

    clear_all();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset(0, "reset0");
    check_reset(1, "reset1");

    for (int k = 0; k < 7; k++) begin
      step();
      do_op(0, vecs[k], $sformatf("vec%0d", k));
    end

    // continuous conflicting requests on both instances
    step();
    lat[0] = 1; lat[1] = 1;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 0, 1'b0, 2'd0, 2'd0, 32'd3, 32'd5);
      set_req(i, 1, 1'b0, 2'd0, 2'd0, 32'd4, 32'd6);
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cgnt[i] && agnt[i]) check($sformatf("prio%0d double gnt", i), 1, 0);
      end
      if (cgnt[0]) win0.push_back(0);
      if (agnt[0]) win0.push_back(1);
      if (cgnt[1]) win1.push_back(0);
      if (agnt[1]) win1.push_back(1);
      step();
    end
    for (int i = 0; i < 2; i++) begin creq[i] = 0; areq[i] = 0; end
    check("prio0 grant count", win0.size(), 4);
    check("prio1 grant count", win1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < win0.size()) check($sformatf("prio0 winner%0d", k), win0[k], 0);
      if (k < win1.size()) check($sformatf("prio1 winner%0d", k), win1[k], k % 2);
    end
    wait_idle("prio");

    // kill mid-BUSY of a core op, with an acc request waiting
    step();
    lat[0] = 6;
    set_req(0, 0, 1'b0, 2'd0, 2'd0, 32'd9, 32'd9);
    @(negedge clk);
    check("kill gnt", cgnt[0], 1);
    saw_crv = 0; saw_rdy = 0; nen = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin creq[0] = 0; set_req(0, 1, 1'b0, 2'd0, 2'd0, 32'd2, 32'd3); end
      if (c == 3) ckill[0] = 1;
      if (c == 4) ckill[0] = 0;
      @(negedge clk);
      if (crv[0]) saw_crv = 1;
      if (mul_en[0]) nen++;
      if (busy[0] && md_ready[0]) saw_rdy = 1;
      if (c == 8) check("kill busy in done", busy[0], 1);
      if (c == 9) begin
        check("kill acc gnt after", agnt[0], 1);
        check("kill busy idle", busy[0], 0);
      end
    end
    check("kill no core_rvalid", saw_crv, 0);
    check("kill unit ran", saw_rdy, 1);
    check("kill en cycles", nen, 7);
    step();
    areq[0] = 0;
    wait_idle("kill");

    // kill together with a core request in IDLE
    step();
    lat[0] = 2;
    set_req(0, 0, 1'b0, 2'd0, 2'd0, 32'd1, 32'd1);
    ckill[0] = 1;
    @(negedge clk);
    check("idle kill gnt", cgnt[0], 0);
    check("idle kill acc gnt", agnt[0], 0);
    step();
    ckill[0] = 0;
    @(negedge clk);
    check("idle kill regnt", cgnt[0], 1);
    step();
    creq[0] = 0;
    wait_idle("idlekill");

    // reset three cycles into a long divide
    step();
    lat[0] = 33;
    set_req(0, 1, 1'b1, 2'd2, 2'd3, 32'd100, 32'd7);
    @(negedge clk);
    check("rst gnt", agnt[0], 1);
    step();
    areq[0] = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("rst div_en%0d", c), div_en[0], 1);
      step();
    end
    rst = 1;
    @(negedge clk);
    step();
    rst = 0;
    @(negedge clk);
    check_reset(0, "midrst");
    step();
    do_op(0, vecs[0], "postrst");

    step();
    rand_run(1, 400);
    rand_run(0, 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/zeroriscy_multdiv_arbiter.md
# zeroriscy_multdiv_arbiter

Arbiter and sequencer that shares the single mult/div unit between two requesters: the core EX stage (port `core`) and the matrix-multiply accelerator's scalar-arithmetic path (port `acc`). It grants one request at a time and latches that request's operands. It holds the unit's enables stable until the unit reports ready, then returns the registered result to the owning requester with a one-cycle valid pulse. It sits in the EX block between the requesters and the mult/div instance and replaces the direct `mult_en`/`div_en` wiring.

## Interface
- `PRIO_MODE`, default 0: 0 = core has fixed priority; 1 = round-robin between core and acc.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_req_i` / `acc_req_i`  in  1  request; held high with stable operands until `*_gnt_o`
- `core_div_i` / `acc_div_i`  in  1  1 = divide/remainder, 0 = multiply
- `core_operator_i` / `acc_operator_i`  in  2  mult/div operator code, passed through
- `core_signed_i` / `acc_signed_i`  in  2  signed mode, passed through
- `core_op_a_i`, `core_op_b_i` / `acc_op_a_i`, `acc_op_b_i`  in  32  operands
- `core_kill_i`  in  1  discard the core's pending or in-flight operation
- `core_gnt_o` / `acc_gnt_o`  out  1  one-cycle grant; operands are captured on this edge
- `core_rvalid_o` / `acc_rvalid_o`  out  1  one-cycle result valid
- `core_rdata_o` / `acc_rdata_o`  out  32  result; both ports are driven from the same result register
- `md_mult_en_o`, `md_div_en_o`  out  1  unit enables; never both high
- `md_operator_o`, `md_signed_mode_o`  out  2  latched operator and signed mode
- `md_op_a_o`, `md_op_b_o`  out  32  latched operands
- `md_ready_i`  in  1  unit done; sampled only in BUSY
- `md_result_i`  in  32  unit result, valid when `md_ready_i` is high
- `busy_o`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**:
  - Evaluate requests and assert `gnt` combinationally for the winner.
  - On that edge, capture div/operator/signed/operands, record owner, clear `killed`, go to BUSY.
  - If no request, stay in IDLE.
- **Arbitration**:
  - `PRIO_MODE=0`: core wins every conflict.
  - `PRIO_MODE=1`: on a conflict, the winner is the port that was not `last_owner`. `last_owner` updates on each grant and resets to acc, so the core wins the first conflict.
  - A lone request always wins.
- **Kill in IDLE**: `core_kill_i` high in IDLE masks `core_req_i` that cycle. The acc port may still be granted.
- **BUSY**:
  - `md_mult_en_o = !div_q`, `md_div_en_o = div_q`; other `md_*` outputs come from the latches.
  - On `md_ready_i`: load `md_result_i` into the result register, go to DONE.
  - `core_kill_i` with owner = core sets `killed`. The operation still runs to completion because the unit cannot be aborted.
- **DONE**:
  - Enables are low.
  - The owner's `rvalid` is high unless `killed`; a kill arriving in DONE also suppresses it.
  - Always go to IDLE next.
  - DONE guarantees at least one cycle of enables low between operations, which lets the unit's internal FSM return to idle.
- **Result hold**: the result register holds until the next completion. Operand latches hold after DONE.
- **Reset**: `rst` at any time, including mid-BUSY, forces IDLE on the next edge. All outputs and registers go to 0; `last_owner` goes to acc. The unit is reset by its own reset in the same cycle.

## Timing
- Reset values: every output is 0; `rdata` = 32'h0.
- Handshake:
  - Grant at cycle T (IDLE with a request).
  - BUSY and enables high from T+1.
  - `md_ready_i` at T+1+k (k ≥ 0) gives DONE and `rvalid` at T+2+k.
  - The next grant is no earlier than T+3+k.
- Throughput: one operation per (unit latency + 2) cycles.
- `gnt` never asserts outside IDLE. A requester that is not granted keeps `req` high; requests are not dropped.
- Only one `*_rvalid_o` is high in any cycle, and never in the same cycle as any `gnt`.
- `md_ready_i` outside BUSY is ignored.

## Test plan
- **Core multiply:** core MUL, a=7, b=-3, unit ready 2 cycles after enable.
  - `core_gnt_o` at T.
  - `md_mult_en_o` high for T+1..T+3.
  - `core_rvalid_o` with `rdata` = 32'hFFFF_FFEB at T+4.
  - Acc outputs stay 0.
- **Simultaneous requests, `PRIO_MODE=0`:** core and acc request simultaneously and continuously.
  - Core is granted every time; acc is never granted.
  - Switch to `PRIO_MODE=1`: grants alternate core, acc, core.
- **Acc divide:** acc DIV, a=100, b=7, 33-cycle unit latency.
  - `md_div_en_o` high for exactly 34 cycles, `md_mult_en_o` stays 0.
  - `acc_rvalid_o` with `rdata` = 14; enables low in the DONE cycle.
- **Kill in flight:** `core_kill_i` asserted mid-BUSY of a core op.
  - The unit still runs to `md_ready_i`.
  - No `core_rvalid_o`; `busy_o` drops after DONE.
  - A pending acc request is granted in the following IDLE cycle.
- **Kill with request in IDLE:** `core_kill_i` with `core_req_i` in IDLE, acc idle.
  - No grant that cycle.
  - Grant next cycle once kill is deasserted.
- **Reset mid-op:** `rst` asserted 3 cycles into a BUSY divide.
  - The next cycle has all outputs 0 and the FSM in IDLE.
  - A fresh core request after `rst` drops is granted with normal latency.
